// File: rtl/bip_uart_pkg.sv
// Shared constants for the BIP-over-UART command link: command bytes,
// loader FSM encoding and the word-count decode rule.
package bip_uart_pkg;

    localparam int unsigned NB_CMD   = 8;
    localparam int unsigned NB_COUNT = 9;

    localparam logic [NB_CMD-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_CMD-1:0] CMD_RUN  = 8'h52;
    localparam logic [NB_CMD-1:0] CMD_HALT = 8'h48;
    localparam logic [NB_CMD-1:0] CMD_STEP = 8'h53;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CNT  = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } loader_state_t;

    // A count byte of zero requests a full 256-word load.
    function automatic logic [NB_COUNT-1:0] word_count(input logic [NB_CMD-1:0] n);
        return (n == '0) ? NB_COUNT'(256) : {1'b0, n};
    endfunction

endpackage

// File: rtl/bip_uart_loader.sv
// Receive-side command decoder: loads instruction words into BIP memory
// and drives the run / single-step execution enable.
module bip_uart_loader
    import bip_uart_pkg::*;
#(
    parameter int unsigned N_DATA             = 8,
    parameter int unsigned NB_DATABIP         = 16,
    parameter int unsigned LOG2_N_INSMEM_ADDR = 11
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [N_DATA-1:0]             i_data,
    input  logic                          i_rx_done,
    output logic                          o_wr_en,
    output logic [LOG2_N_INSMEM_ADDR-1:0] o_wr_addr,
    output logic [NB_DATABIP-1:0]         o_wr_data,
    output logic                          o_valid,
    output logic                          o_run,
    output logic                          o_busy,
    output logic                          o_load_done,
    output logic                          o_error
);

    localparam logic [LOG2_N_INSMEM_ADDR-1:0] ADDR_ONE = 1;
    localparam logic [NB_COUNT-1:0]           CNT_ONE  = 1;

    loader_state_t                   state;
    logic [N_DATA-1:0]               hi_byte;
    logic [NB_COUNT-1:0]             remaining;
    logic [LOG2_N_INSMEM_ADDR-1:0]   addr;
    logic                            step;

    // Step pulse is only ever raised while o_run is low, so the OR is exact.
    assign o_valid = o_run | step;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            hi_byte     <= '0;
            remaining   <= '0;
            addr        <= '0;
            step        <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_run       <= 1'b0;
            o_busy      <= 1'b0;
            o_load_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_wr_en     <= 1'b0;
            o_load_done <= 1'b0;
            o_error     <= 1'b0;
            step        <= 1'b0;
            // busy spans the load_done cycle, then drops
            if (o_load_done) begin
                o_busy <= 1'b0;
            end
            if (i_rx_done) begin
                case (state)
                    ST_IDLE: begin
                        case (i_data)
                            CMD_LOAD: begin
                                state  <= ST_CNT;
                                o_run  <= 1'b0;
                                o_busy <= 1'b1;
                            end
                            CMD_RUN:  o_run <= 1'b1;
                            CMD_HALT: o_run <= 1'b0;
                            CMD_STEP: step  <= ~o_run;
                            default:  o_error <= 1'b1;
                        endcase
                    end
                    ST_CNT: begin
                        remaining <= word_count(i_data);
                        addr      <= '0;
                        state     <= ST_HI;
                    end
                    ST_HI: begin
                        hi_byte <= i_data;
                        state   <= ST_LO;
                    end
                    ST_LO: begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= addr;
                        o_wr_data <= {hi_byte, i_data};
                        addr      <= addr + ADDR_ONE;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state       <= ST_IDLE;
                            o_load_done <= 1'b1;
                        end else begin
                            state <= ST_HI;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bip_uart_loader.sv
// Directed self-checking bench for bip_uart_loader.
module tb_bip_uart_loader;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_data;
    logic        i_rx_done;
    logic        o_wr_en;
    logic [10:0] o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_valid;
    logic        o_run;
    logic        o_busy;
    logic        o_load_done;
    logic        o_error;

    int checks   = 0;
    int failures = 0;

    int          wr_count   = 0;
    int          done_count = 0;
    int          err_count  = 0;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    bip_uart_loader dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_rx_done   (i_rx_done),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_valid     (o_valid),
        .o_run       (o_run),
        .o_busy      (o_busy),
        .o_load_done (o_load_done),
        .o_error     (o_error)
    );

    // Pulse monitor, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (o_wr_en) begin
            wr_count++;
            if (o_wr_addr < 11'd256) mem[o_wr_addr[7:0]] = o_wr_data;
        end
        if (o_load_done) done_count++;
        if (o_error) err_count++;
    end

    // Called at a falling edge; returns at the next falling edge where the
    // registered response to this byte is visible.
    task automatic send(input logic [7:0] b);
        i_data    = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        i_data    = 8'h00;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_rx_done = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_valid, o_run, o_busy, o_load_done, o_error} !== 33'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_wr_en, o_wr_addr, o_wr_data, o_valid, o_run, o_busy, o_load_done, o_error});
        end
        // byte arriving with reset is dropped
        i_data = 8'h52; i_rx_done = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0; i_reset = 1'b0;
        tick();
        checks++;
        if (o_run !== 1'b0) begin
            failures++;
            $display("FAIL reset_drops_byte: got run=%b expected 0", o_run);
        end
    endtask

    task automatic test_load();
        send(8'h4C);
        checks++;
        if (o_busy !== 1'b1 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_busy_rise: got busy=%b wr_en=%b expected 1/0", o_busy, o_wr_en);
        end
        send(8'h02);
        send(8'h12);
        checks++;
        if (o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_hi_no_write: got wr_en=%b expected 0", o_wr_en);
        end
        send(8'h34);
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 11'd0 || o_wr_data !== 16'h1234 || o_load_done !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL load_word0: got en=%b addr=%h data=%h done=%b busy=%b expected 1/000/1234/0/1",
                     o_wr_en, o_wr_addr, o_wr_data, o_load_done, o_busy);
        end
        send(8'hAB);
        checks++;
        if (o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_wr_en_width: got wr_en=%b expected 0", o_wr_en);
        end
        send(8'hCD);
        checks++;
        if (o_wr_en !== 1'b1 || o_wr_addr !== 11'd1 || o_wr_data !== 16'hABCD || o_load_done !== 1'b1 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL load_word1: got en=%b addr=%h data=%h done=%b busy=%b expected 1/001/abcd/1/1",
                     o_wr_en, o_wr_addr, o_wr_data, o_load_done, o_busy);
        end
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_load_done !== 1'b0 || o_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_end: got busy=%b done=%b wr_en=%b expected 0/0/0", o_busy, o_load_done, o_wr_en);
        end
    endtask

    task automatic test_full_load();
        int w0, d0, bad;
        logic [7:0] lo;
        for (int k = 0; k < 256; k++) mem[k] = 16'hDEAD;
        w0 = wr_count; d0 = done_count; bad = 0;
        send(8'h4C);
        send(8'h00);
        for (int k = 0; k < 256; k++) begin
            lo = 8'(k) ^ 8'h5A;
            send(8'(k));
            send(lo);
        end
        chk("full_last_addr", 32'(o_wr_addr), 32'd255);
        chk("full_done_pulse", 32'(o_load_done), 32'd1);
        tick();
        chk("full_write_count", 32'(wr_count - w0), 32'd256);
        chk("full_done_count", 32'(done_count - d0), 32'd1);
        for (int k = 0; k < 256; k++) begin
            lo = 8'(k) ^ 8'h5A;
            if (mem[k] !== {8'(k), lo}) bad++;
        end
        chk("full_mem_contents_bad", 32'(bad), 32'd0);
        chk("full_busy_low", 32'(o_busy), 32'd0);
        send(8'h52);
        chk("full_then_run", 32'({o_run, o_valid}), 32'b11);
    endtask

    task automatic test_run_step_halt();
        send(8'h48);
        chk("rsh_halt_first", 32'({o_run, o_valid}), 32'b00);
        send(8'h52);
        chk("rsh_run", 32'({o_run, o_valid}), 32'b11);
        send(8'h53);
        chk("rsh_step_while_run", 32'({o_run, o_valid}), 32'b11);
        tick();
        chk("rsh_step_ignored", 32'({o_run, o_valid}), 32'b11);
        send(8'h48);
        chk("rsh_halt", 32'({o_run, o_valid}), 32'b00);
        send(8'h53);
        chk("rsh_step_pulse", 32'({o_run, o_valid}), 32'b01);
        tick();
        chk("rsh_step_width", 32'({o_run, o_valid}), 32'b00);
    endtask

    task automatic test_unknown();
        int e0;
        e0 = err_count;
        send(8'h7F);
        chk("unk_error_pulse", 32'(o_error), 32'd1);
        chk("unk_no_side_effect", 32'({o_wr_en, o_run, o_valid, o_busy, o_load_done}), 32'd0);
        tick();
        chk("unk_error_width", 32'(o_error), 32'd0);
        chk("unk_error_count", 32'(err_count - e0), 32'd1);
        send(8'h52);
        chk("unk_then_run", 32'(o_run), 32'd1);
    endtask

    task automatic test_data_not_cmd();
        send(8'h4C);
        chk("dnc_run_cleared", 32'({o_run, o_busy}), 32'b01);
        send(8'h01);
        send(8'h52);
        chk("dnc_hi_not_run", 32'(o_run), 32'd0);
        send(8'h48);
        chk("dnc_write", 32'({o_wr_en, o_wr_addr, o_wr_data, o_load_done}), {1'b0, 2'b00, 1'b1, 11'd0, 16'h5248, 1'b1});
        tick();
        chk("dnc_run_still_low", 32'({o_run, o_busy}), 32'b00);
    endtask

    task automatic test_reset_mid_load();
        int d0;
        d0 = done_count;
        send(8'h4C);
        send(8'h03);
        send(8'h11);
        send(8'h22);
        chk("rml_first_word", 32'({o_wr_en, o_wr_data}), {15'd0, 1'b1, 16'h1122});
        send(8'h33);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        checks++;
        if ({o_wr_en, o_wr_addr, o_wr_data, o_valid, o_run, o_busy, o_load_done, o_error} !== 33'h0) begin
            failures++;
            $display("FAIL rml_outputs_zero: got %h expected 0",
                     {o_wr_en, o_wr_addr, o_wr_data, o_valid, o_run, o_busy, o_load_done, o_error});
        end
        tick();
        chk("rml_no_done", 32'(done_count - d0), 32'd0);
        send(8'h4C);
        send(8'h01);
        send(8'hAA);
        send(8'hBB);
        chk("rml_reload_write", 32'({o_wr_en, o_wr_addr, o_wr_data, o_load_done}), {1'b0, 2'b00, 1'b1, 11'd0, 16'hAABB, 1'b1});
        tick();
    endtask

    initial begin
        i_reset = 1'b1; i_rx_done = 1'b0; i_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_load();
        test_full_load();
        test_run_step_halt();
        test_unknown();
        test_data_not_cmd();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
